// File: rtl/stack_queue_ctl_if.sv
// rtl/stack_queue_ctl_if.sv - request/status bundle for the stack/queue controller
interface stack_queue_ctl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             mode;
    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic             active_mode;

    modport master (
        output mode, clr, push, pop, data_in,
        input  data_out, count, empty, full, almost_empty, almost_full,
               overflow, underflow, active_mode
    );

    modport slave (
        input  mode, clr, push, pop, data_in,
        output data_out, count, empty, full, almost_empty, almost_full,
               overflow, underflow, active_mode
    );
endinterface

// File: rtl/stack_queue_ctl.sv
// rtl/stack_queue_ctl.sv - LIFO/FIFO buffer with selectable order, sticky error flags
module stack_queue_ctl #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic clk,
    input  logic rst,
    stack_queue_ctl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q, udf_q, amode_q;

    logic [PW-1:0]    wr_inc, wr_dec, rd_inc;
    logic             is_empty, is_full;
    logic             mem_we;
    logic [PW-1:0]    mem_waddr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PTR_LAST : p - PTR_ONE;
    endfunction

    assign wr_inc   = ptr_inc(wr_q);
    assign wr_dec   = ptr_dec(wr_q);
    assign rd_inc   = ptr_inc(rd_q);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_MAX);

    // Only a LIFO push+pop overwrites the top entry in place; all other writes land at wr.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_q;
        if (!bus.clr && bus.push) begin
            if (bus.pop && !is_empty) begin
                mem_we = 1'b1;
                if (!amode_q) mem_waddr = wr_dec;
            end else if (bus.pop || !is_full) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            amode_q <= 1'b0;
        end else if (bus.clr) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            // Order may only change while empty, so no live entries get reinterpreted.
            if (is_empty) amode_q <= bus.mode;

            if (bus.push && bus.pop) begin
                if (is_empty) begin
                    wr_q    <= wr_inc;
                    count_q <= CNT_ONE;
                    udf_q   <= 1'b1;
                end else if (!amode_q) begin
                    dout_q <= mem[wr_dec];
                end else begin
                    dout_q <= mem[rd_q];
                    rd_q   <= rd_inc;
                    wr_q   <= wr_inc;
                end
            end else if (bus.push) begin
                if (is_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    wr_q    <= wr_inc;
                    count_q <= count_q + CNT_ONE;
                end
            end else if (bus.pop) begin
                if (is_empty) begin
                    udf_q <= 1'b1;
                end else begin
                    count_q <= count_q - CNT_ONE;
                    if (!amode_q) begin
                        dout_q <= mem[wr_dec];
                        wr_q   <= wr_dec;
                    end else begin
                        dout_q <= mem[rd_q];
                        rd_q   <= rd_inc;
                    end
                end
            end
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.active_mode  = amode_q;
endmodule

// File: tb/tb_stack_queue_ctl.sv
// tb/tb_stack_queue_ctl.sv - randomized and directed bench for stack_queue_ctl
module tb_stack_queue_ctl;
    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_queue_ctl_if #(.WIDTH(W), .DEPTH(D)) bus ();
    stack_queue_ctl #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_ovf, m_udf, m_amode;

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_amode = 1'b0;
    endtask

    task automatic model_edge(input logic m, c, pu, po, input logic [W-1:0] d);
        logic lifo;
        lifo = !m_amode;
        if (c) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            if (q.size() == 0) m_amode = m;
            if (pu && po) begin
                if (q.size() == 0) begin
                    q.push_back(d);
                    m_udf = 1'b1;
                end else if (lifo) begin
                    m_dout = q[q.size()-1];
                    q[q.size()-1] = d;
                end else begin
                    m_dout = q.pop_front();
                    q.push_back(d);
                end
            end else if (pu) begin
                if (q.size() == D) m_ovf = 1'b1;
                else q.push_back(d);
            end else if (po) begin
                if (q.size() == 0) m_udf = 1'b1;
                else if (lifo) m_dout = q.pop_back();
                else m_dout = q.pop_front();
            end
        end
    endtask

    task automatic step(input logic m, c, pu, po, input logic [W-1:0] d);
        bus.mode    = m;
        bus.clr     = c;
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        @(posedge clk);
        model_edge(m, c, pu, po, d);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests_run++; if (bus.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", bus.count); end
        tests_run++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b/%b want 1/1", bus.empty, bus.almost_empty); end
        tests_run++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b/%b want 0/0", bus.full, bus.almost_full); end
        tests_run++; if (bus.data_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_dout got %h want 0000", bus.data_out); end
        tests_run++; if ({bus.overflow, bus.underflow, bus.active_mode} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {bus.overflow, bus.underflow, bus.active_mode}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_lifo();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1};
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h00A0 + 16'(i));
        tests_run++; if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.almost_full !== 1'b1) begin tests_failed++; $display("FAIL lifo_fill got full=%b count=%0d af=%b want 1/4/1", bus.full, bus.count, bus.almost_full); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h00A5);
        tests_run++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin tests_failed++; $display("FAIL lifo_ovf got ovf=%b count=%0d want 1/4", bus.overflow, bus.count); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, '0);
            tests_run++; if (bus.data_out !== exp_seq[i]) begin tests_failed++; $display("FAIL lifo_pop%0d got %h want %h", i, bus.data_out, exp_seq[i]); end
        end
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL lifo_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_fifo_wrap();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{16'h00B3, 16'h00B4, 16'h00B5, 16'h00B6};
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tests_run++; if (bus.active_mode !== 1'b1) begin tests_failed++; $display("FAIL fifo_mode got %b want 1", bus.active_mode); end
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h00B0 + 16'(i));
        step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 4; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h00B0 + 16'(i));
        tests_run++; if (bus.count !== 3'd4) begin tests_failed++; $display("FAIL fifo_count got %0d want 4", bus.count); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, '0);
            tests_run++; if (bus.data_out !== exp_seq[i]) begin tests_failed++; $display("FAIL fifo_pop%0d got %h want %h", i, bus.data_out, exp_seq[i]); end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h00C1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h00C2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h00C3);
        tests_run++; if (bus.data_out !== 16'h00C2 || bus.count !== 3'd2) begin tests_failed++; $display("FAIL lifo_pp got %h/%0d want 00c2/2", bus.data_out, bus.count); end
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tests_run++; if (bus.data_out !== 16'h00C3) begin tests_failed++; $display("FAIL lifo_pp_next got %h want 00c3", bus.data_out); end
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h00D0 + 16'(i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h00D5);
        tests_run++; if (bus.data_out !== 16'h00D1 || bus.count !== 3'd4 || bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL fifo_pp_full got %h/%0d/%b want 00d1/4/0", bus.data_out, bus.count, bus.overflow); end
    endtask

    task automatic test_underflow_clr();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tests_run++; if (bus.underflow !== 1'b1 || bus.data_out !== 16'h5A5A) begin tests_failed++; $display("FAIL udf_pop got udf=%b dout=%h want 1/5a5a", bus.underflow, bus.data_out); end
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        tests_run++; if (bus.count !== 3'd1 || bus.underflow !== 1'b1 || bus.data_out !== 16'h5A5A) begin tests_failed++; $display("FAIL udf_pp got %0d/%b/%h want 1/1/5a5a", bus.count, bus.underflow, bus.data_out); end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tests_run++; if (bus.count !== 3'd0 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0 || bus.data_out !== 16'h0000) begin tests_failed++; $display("FAIL clr got %0d/%b/%b/%h want 0/0/0/0000", bus.count, bus.underflow, bus.overflow, bus.data_out); end
    endtask

    task automatic test_mode_lock_async();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'(i + 7));
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tests_run++; if (bus.active_mode !== 1'b0 || bus.count !== 3'd3) begin tests_failed++; $display("FAIL mode_lock got %b/%0d want 0/3", bus.active_mode, bus.count); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin tests_failed++; $display("FAIL async_rst got %0d/%b want 0/1", bus.count, bus.empty); end
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic m, c, pu, po;
        logic [W-1:0] d;
        int n;
        for (int i = 0; i < 400; i++) begin
            m  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 19) == 0);
            pu = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            step(m, c, pu, po, d);
            n = q.size();
            tests_run++;
            if (bus.data_out !== m_dout || bus.count !== 3'(n) || bus.empty !== (n == 0) ||
                bus.full !== (n == D) || bus.almost_empty !== (n <= 1) || bus.almost_full !== (n >= D - 1) ||
                bus.overflow !== m_ovf || bus.underflow !== m_udf || bus.active_mode !== m_amode) begin
                tests_failed++;
                $display("FAIL rand%0d got dout=%h cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b am=%b want dout=%h cnt=%0d ovf=%b udf=%b am=%b",
                         i, bus.data_out, bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                         bus.overflow, bus.underflow, bus.active_mode, m_dout, n, m_ovf, m_udf, m_amode);
            end
        end
    endtask

    initial begin
        bus.mode = 1'b0; bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        model_reset();
        test_reset();
        test_lifo();
        test_fifo_wrap();
        test_back_to_back();
        test_underflow_clr();
        test_mode_lock_async();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/stack_queue_ctl.md
STACK_QUEUE_CTL -- requirements
Module: stack_queue_ctl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 16, data word width.
- DEPTH, 4, entry count; any integer >= 2, not required to be a power of two.
- AF_LEVEL, DEPTH-1, almost_full threshold.
- AE_LEVEL, 1, almost_empty threshold.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- mode, in, 1, requested order; 0 = LIFO, 1 = FIFO.
- clr, in, 1, synchronous flush.
- push, in, 1, write request.
- pop, in, 1, read request.
- data_in, in, WIDTH, write data.
- data_out, out, WIDTH, registered read data.
- count, out, $clog2(DEPTH+1), current occupancy.
- empty, out, 1, high when count==0.
- full, out, 1, high when count==DEPTH.
- almost_empty, out, 1, high when count<=AE_LEVEL.
- almost_full, out, 1, high when count>=AF_LEVEL.
- overflow, out, 1, sticky error flag.
- underflow, out, 1, sticky error flag.
- active_mode, out, 1, mode currently in force.

Function
REQ-003 Storage SHALL be a DEPTH-entry array addressed by a read pointer rd and a write pointer wr; each pointer SHALL wrap from DEPTH-1 to 0 on increment and from 0 to DEPTH-1 on decrement.
REQ-004 active_mode SHALL load from mode on any edge where count==0 and clr==0; while count!=0, mode changes SHALL be ignored.
REQ-005 Priority per edge SHALL be: clr > push/pop.
- clr=1: count, rd and wr go to 0; overflow, underflow and data_out go to 0; push and pop are ignored.
REQ-006 Accepted push alone (not full): mem[wr]<=data_in, wr increments, count+1. This is the same in both modes.
REQ-007 Accepted pop alone (not empty):
- LIFO: data_out<=mem[wr-1], wr decrements, count-1.
- FIFO: data_out<=mem[rd], rd increments, count-1.
REQ-008 data_out SHALL update only on an accepted pop (one-cycle read latency) and SHALL hold its value otherwise.
REQ-009 Push alone while full SHALL be ignored and SHALL set overflow.
REQ-010 Pop alone while empty SHALL be ignored, SHALL set underflow, and data_out SHALL hold.
REQ-011 push=pop=1 with count>0, LIFO: data_out<=mem[wr-1], mem[wr-1]<=data_in, wr and count unchanged; this is legal when full.
REQ-012 push=pop=1 with count>0, FIFO: data_out<=mem[rd], mem[wr]<=data_in, both pointers increment, count unchanged; this is legal when full.
REQ-013 push=pop=1 with count==0: push accepted as in REQ-006; pop rejected; underflow set; data_out holds.
REQ-014 overflow and underflow SHALL stay set until clr or rst.
REQ-015 empty, full, almost_empty and almost_full SHALL decode combinationally from the count register only.
REQ-016 count SHALL never exceed DEPTH and never go below 0 under any input sequence.

Reset
REQ-017 While rst=1, asynchronously:
- count, rd, wr, data_out, overflow, underflow and active_mode SHALL be 0.
- empty=1, almost_empty=1, full=0, almost_full=0 (assuming AF_LEVEL>0).
REQ-018 Array contents SHALL NOT need reset.
REQ-019 rst asserted mid-operation SHALL clear state immediately, without waiting for a clock edge.
REQ-020 The first edge after rst deasserts SHALL behave as an edge from the empty state.

Verification (WIDTH=16, DEPTH=4)
REQ-021 Reset: rst=1 -> count=0, empty=1, full=0, data_out=0x0000, overflow=0, underflow=0, active_mode=0.
REQ-022 LIFO fill/drain:
- Push 0xA1,0xA2,0xA3,0xA4 -> full=1, count=4, almost_full=1.
- Push 0xA5 -> overflow=1, count=4.
- Four pops -> data_out 0xA4,0xA3,0xA2,0xA1, each one edge after its pop; then empty=1.
REQ-023 FIFO order and wrap:
- mode=1 while empty -> active_mode=1.
- Push 0xB1..0xB3, pop 2, push 0xB4,0xB5,0xB6 (wraps) -> count=4.
- Four pops -> 0xB3,0xB4,0xB5,0xB6.
REQ-024 Simultaneous push+pop:
- LIFO holding 0xC1,0xC2; push=pop=1 with data_in=0xC3 -> data_out=0xC2, count=2; next pop -> 0xC3.
- FIFO full; push=pop=1 -> oldest word out, count stays 4, overflow stays 0.
REQ-025 Underflow/clr:
- Pop while empty -> underflow=1, data_out unchanged.
- push=pop=1 while empty -> count=1, underflow=1.
- clr=1 -> count=0, both flags 0, data_out=0.
REQ-026 Mode lock/async reset:
- mode toggled with count=3 -> active_mode unchanged.
- rst pulsed between edges -> count=0, empty=1 before the next clk edge.
